// File: rtl/fetch_queue_unit.sv
// Instruction fetch front end: sequential PC generation, pipelined imem reads, DEPTH-entry decode queue.
// Latency: rvalid at edge N -> dec_valid_o in cycle N+1; request issue is combinational from state.
// Backpressure: issue is credit-limited (occupancy + outstanding < DEPTH); decode pops via valid/ready.
module fetch_queue_unit #(
  parameter int              XLEN            = 32,
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_waitrequest_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            dec_valid_o,
  input  logic            dec_ready_i,
  output logic [31:0]     dec_instr_o,
  output logic [XLEN-1:0] dec_pc_o,
  output logic [XLEN-1:0] dec_pc4_o,
  output logic [XLEN-1:0] fetch_pc_o
);

  localparam int QAW = $clog2(DEPTH);
  localparam int QCW = $clog2(DEPTH + 1);
  localparam int TAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OCW = $clog2(MAX_OUTSTANDING + 1);

  logic [XLEN-1:0] fetch_pc;
  logic [31:0]     q_instr [DEPTH];
  logic [XLEN-1:0] q_pc    [DEPTH];
  logic [XLEN-1:0] q_pc4   [DEPTH];
  logic [QAW-1:0]  q_rd, q_wr;
  logic [QCW-1:0]  q_cnt;
  logic [XLEN-1:0] tag_mem [MAX_OUTSTANDING];
  logic [TAW-1:0]  tag_rd, tag_wr;
  logic [OCW-1:0]  outst, outst_next, drop;
  logic            accept, resp, keep, pop;
  logic [XLEN-1:0] tag_head;

  // Issue gating, response classification and decode handshake.
  always_comb begin
    imem_req_o  = rst && !redirect_i
                  && (32'(outst) < 32'(MAX_OUTSTANDING))
                  && (32'(q_cnt) + 32'(outst) < 32'(DEPTH));
    imem_addr_o = fetch_pc;
    fetch_pc_o  = fetch_pc;
    accept      = imem_req_o && !imem_waitrequest_i;
    // A response with nothing outstanding is a protocol error and is ignored.
    resp        = imem_rvalid_i && (outst != '0);
    // Responses are discarded while owed to an earlier redirect or during a redirect cycle.
    keep        = resp && (drop == '0) && !redirect_i;
    dec_valid_o = (q_cnt != '0) && !redirect_i;
    pop         = dec_valid_o && dec_ready_i;
    tag_head    = tag_mem[tag_rd];
    dec_instr_o = q_instr[q_rd];
    dec_pc_o    = q_pc[q_rd];
    dec_pc4_o   = q_pc4[q_rd];
    outst_next  = outst;
    if (accept && !resp)      outst_next = outst + OCW'(1);
    else if (!accept && resp) outst_next = outst - OCW'(1);
  end

  // Fetch PC, PC tag FIFO for in-flight requests, outstanding and drop counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      tag_rd   <= '0;
      tag_wr   <= '0;
      outst    <= '0;
      drop     <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) tag_mem[i] <= '0;
    end else begin
      outst <= outst_next;
      if (accept) begin
        tag_mem[tag_wr] <= fetch_pc;
        tag_wr          <= (tag_wr == TAW'(MAX_OUTSTANDING - 1)) ? '0 : tag_wr + TAW'(1);
      end
      if (resp)
        tag_rd <= (tag_rd == TAW'(MAX_OUTSTANDING - 1)) ? '0 : tag_rd + TAW'(1);
      if (redirect_i) begin
        fetch_pc <= {redirect_pc_i[XLEN-1:2], 2'b00};
        // Everything still in flight after this edge belongs to the old stream.
        drop     <= outst_next;
      end else begin
        if (accept)                fetch_pc <= fetch_pc + XLEN'(4);
        if (resp && drop != '0)    drop     <= drop - OCW'(1);
      end
    end
  end

  // Decode queue: push kept responses at the tail, pop on handshake, flush on redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_rd  <= '0;
      q_wr  <= '0;
      q_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
        q_pc4[i]   <= '0;
      end
    end else if (redirect_i) begin
      q_rd  <= '0;
      q_wr  <= '0;
      q_cnt <= '0;
    end else begin
      if (keep) begin
        q_instr[q_wr] <= imem_rdata_i;
        q_pc[q_wr]    <= tag_head;
        q_pc4[q_wr]   <= tag_head + XLEN'(4);
        q_wr          <= q_wr + QAW'(1);
      end
      if (pop) q_rd <= q_rd + QAW'(1);
      if (keep && !pop)      q_cnt <= q_cnt + QCW'(1);
      else if (!keep && pop) q_cnt <= q_cnt - QCW'(1);
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: queue-level reference model plus in-order pipelined memory model.
// Inputs driven at negedge, outputs compared 1ns later, model advanced at posedge.
// Directed scenarios pin the model with literal expectations; a random phase follows.
module tb_fetch_queue_unit;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_waitrequest_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        dec_valid_o;
  logic        dec_ready_i = 1'b0;
  logic [31:0] dec_instr_o, dec_pc_o, dec_pc4_o, fetch_pc_o;

  fetch_queue_unit #(.XLEN(32), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_waitrequest_i(imem_waitrequest_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .dec_valid_o(dec_valid_o),
    .dec_ready_i(dec_ready_i), .dec_instr_o(dec_instr_o), .dec_pc_o(dec_pc_o),
    .dec_pc4_o(dec_pc4_o), .fetch_pc_o(fetch_pc_o));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: next fetch PC, PCs in flight, decode queue of PCs, responses owed.
  logic [31:0] m_pc;
  logic [31:0] m_tags[$];
  logic [31:0] m_q[$];
  int          m_drop;

  // Memory model: in-order responses, each due at a cycle index.
  typedef struct { logic [31:0] a; int due; } mreq_t;
  mreq_t memq[$];
  int    last_due, lat, extra_max, cyc, dut_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[31:16]};
  endfunction

  // One clock: entered at a negedge, returns at the next negedge.
  task automatic cycle(input bit redir, input logic [31:0] rpc, input bit wr, input bit rdy);
    bit e_req, e_dv, rv, acc;
    logic [31:0] t;
    int due;
    redirect_i = redir; redirect_pc_i = rpc; imem_waitrequest_i = wr; dec_ready_i = rdy;
    rv = (memq.size() > 0) && (memq[0].due <= cyc);
    imem_rvalid_i = rv;
    imem_rdata_i  = rv ? instr_of(memq[0].a) : 32'hDEAD_BEEF;
    #1;
    e_req = !redir && (m_tags.size() < MAXO) && (m_q.size() + m_tags.size() < DEPTH);
    e_dv  = (m_q.size() > 0) && !redir;
    chk("imem_req", imem_req_o, e_req);
    chk("imem_addr", imem_addr_o, m_pc);
    chk("fetch_pc", fetch_pc_o, m_pc);
    chk("dec_valid", dec_valid_o, e_dv);
    if (m_q.size() > 0) begin
      chk("dec_pc", dec_pc_o, m_q[0]);
      chk("dec_pc4", dec_pc4_o, m_q[0] + 32'd4);
      chk("dec_instr", dec_instr_o, instr_of(m_q[0]));
    end
    if (imem_req_o && !wr) dut_acc++;
    @(posedge clk);
    acc = e_req && !wr;
    if (e_dv && rdy) void'(m_q.pop_front());
    if (rv) begin
      void'(memq.pop_front());
      if (m_tags.size() > 0) begin
        t = m_tags.pop_front();
        if (!redir) begin
          if (m_drop > 0) m_drop--;
          else m_q.push_back(t);
        end
      end
    end
    if (acc) begin
      due = cyc + lat + ((extra_max > 0) ? int'($urandom_range(extra_max, 0)) : 0);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      memq.push_back('{a: m_pc, due: due});
      m_tags.push_back(m_pc);
      m_pc = m_pc + 32'd4;
    end
    if (redir) begin
      m_q.delete();
      m_pc   = {rpc[31:2], 2'b00};
      m_drop = m_tags.size();
    end
    cyc++;
    @(negedge clk);
  endtask

  // Assert reset asynchronously mid-cycle, check cleared outputs, release at a negedge.
  task automatic do_reset();
    #2;
    rst = 1'b0;
    redirect_i = 0; imem_waitrequest_i = 0; imem_rvalid_i = 0; dec_ready_i = 0;
    #1;
    chk("rst_req", imem_req_o, 0);
    chk("rst_dec_valid", dec_valid_o, 0);
    chk("rst_dec_instr", dec_instr_o, 0);
    chk("rst_dec_pc", dec_pc_o, 0);
    chk("rst_dec_pc4", dec_pc4_o, 0);
    chk("rst_fetch_pc", fetch_pc_o, 0);
    m_pc = 32'h0; m_tags.delete(); m_q.delete(); m_drop = 0;
    memq.delete(); last_due = cyc; dut_acc = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Run with decode ready until the head is valid, then pin its PC.
  task automatic wait_head(input logic [31:0] exp_pc);
    int n = 0;
    while (!dec_valid_o && n < 20) begin
      cycle(0, 0, 0, 1);
      n++;
    end
    if (!dec_valid_o) begin
      checks++; errors++;
      $display("FAIL wait_head timeout: dec_valid_o stayed 0, required head pc %h", exp_pc);
    end else chk("first_head_pc", dec_pc_o, exp_pc);
  endtask

  initial begin
    cyc = 0; lat = 1; extra_max = 0; last_due = 0; dut_acc = 0;
    @(negedge clk);

    // Streaming with a 1-cycle memory: decode sees 0,4,8 from the third cycle.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      cycle(0, 0, 0, 1);
      if (k >= 1 && k <= 3) chk("stream_pc", dec_pc_o, 32'(4 * (k - 1)));
    end

    // Stalled decode: exactly DEPTH requests accepted, head holds 0, then ordered drain.
    do_reset();
    repeat (10) cycle(0, 0, 0, 0);
    chk("stall_accepts", dut_acc, 4);
    chk("stall_req_low", imem_req_o, 0);
    chk("stall_head_pc", dec_pc_o, 0);
    repeat (12) cycle(0, 0, 0, 1);

    // Waitrequest on address 8 holds the address for three cycles.
    do_reset();
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      cycle(0, 0, 1, 1);
      chk("wait_addr_hold", imem_addr_o, 32'h8);
    end
    repeat (8) cycle(0, 0, 0, 1);

    // Latency-3 memory, two in flight, redirect to an unaligned target.
    do_reset();
    lat = 3;
    cycle(1, 32'h10, 0, 1);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    cycle(1, 32'h203, 0, 1);
    chk("redir_addr", imem_addr_o, 32'h200);
    wait_head(32'h200);
    repeat (6) cycle(0, 0, 0, 1);

    // Redirect while a response returns in a steady stream.
    do_reset();
    lat = 1;
    repeat (5) cycle(0, 0, 0, 1);
    cycle(1, 32'h400, 0, 1);
    wait_head(32'h400);
    repeat (4) cycle(0, 0, 0, 1);

    // Address wrap at the top of the space.
    do_reset();
    cycle(1, 32'hFFFF_FFFF, 0, 1);
    chk("wrap_addr0", imem_addr_o, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 1);
    chk("wrap_addr1", imem_addr_o, 32'h0);
    wait_head(32'hFFFF_FFFC);
    chk("wrap_pc4", dec_pc4_o, 32'h0);
    repeat (4) cycle(0, 0, 0, 1);

    // Randomized traffic with occasional mid-run resets.
    extra_max = 2;
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 350) do_reset();
      if (i % 100 == 0) lat = int'($urandom_range(3, 1));
      cycle(($urandom % 25) == 0, $urandom, ($urandom % 4) == 0, ($urandom % 3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
